muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Multi-cycle RV32M/RV64M multiply/divide execute unit, parametrised in XLEN, sitting beside the ALU in the Execute stage of the pipelined core. It accepts one operation per start pulse and runs it iteratively. It asserts busy so the hazard unit stalls Fetch/Decode/Execute, then pulses done with the result for the Memory pipeline register. A branch redirect flush from the pipeline aborts any in-flight operation.

Parameters:
XLEN, 32, operand/result width; legal values 32 or 64
DIV_EARLY_OUT, 1, when 1, divide-by-zero and signed overflow complete without iterating

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
funct3  input  3  RISC-V M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 value (after forwarding mux)
op_b  input  XLEN  rs2 value (after forwarding mux)
flush  input  1  abort in-flight op (Execute flush)
busy  output  1  operation in progress; stall request to hazard unit
done  output  1  one-cycle pulse, result valid
result  output  XLEN  result; held until next accepted start

Behaviour:
- Reset (RST=1 at CLK edge): state=IDLE, busy=0, done=0, result=0, counter=0. RST overrides start and flush, and aborts any op mid-flight with no done.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE: start=1 and flush=0 latch funct3, op_a and op_b, then go to MUL (funct3[2]=0) or DIV (funct3[2]=1). busy rises in the cycle after start.
- start while busy=1 is ignored. No queueing.
- Operands are converted to magnitudes at latch time:
  - MULH/DIV/REM: op_a and op_b are signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - MUL: signedness is irrelevant to the low XLEN bits.
  - The result sign is recorded in a latched flag.
- MUL: shift-add, one bit per cycle, XLEN cycles, 2*XLEN-bit product register.
- DIV: restoring divide, one quotient bit per cycle, XLEN cycles, XLEN+1-bit partial remainder.
- FIX: one cycle. Applies two's-complement negation if the sign flag is set, then selects the result:
  - MUL: low half.
  - MULH*: high half.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder, which takes the sign of the dividend.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency from start cycle T (iterative path): done at T+XLEN+2. A back-to-back start is accepted in the DONE cycle.
- Divide by zero (op_b=0): quotient = all ones (-1 signed / 2^XLEN-1 unsigned); remainder = op_a.
- Signed overflow (op_a=-2^(XLEN-1), op_b=-1, DIV/REM only): quotient = op_a, remainder = 0.
- With DIV_EARLY_OUT=1, both special cases skip DIV and go straight to FIX, giving done at T+2. With DIV_EARLY_OUT=0 they iterate the full XLEN cycles but produce identical results.
- flush=1 in any state except IDLE: next state is IDLE, busy=0, no done pulse, result unchanged.
- flush and start in the same cycle in IDLE: flush wins and the op is not accepted.
- Counter: log2(XLEN)+1 bits. It is loaded with XLEN-1 on entry to MUL/DIV and the state exits when it reaches 0, with no wrap.
- No X propagation: result is only updated in FIX.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: MUL* ops use a single-cycle combinational XLEN x XLEN signed/unsigned multiplier. The path is IDLE -> FIX -> DONE, so done arrives at T+2. Divide is unchanged.
- Undefined: iterative shift-add MUL path as above, with no multiplier inferred.

Decomposition:
- Package muldiv_pkg holds:
  - the funct3 enum (MD_MUL..MD_REMU);
  - the state enum muldiv_state_t;
  - the XLEN-independent helpers: is_signed_a(funct3), is_signed_b(funct3), is_div(funct3).
- Sub-module muldiv_div_core: iterative restoring divider with ports CLK, RST, load, flush, dividend, divisor, quotient, remainder and fin. It keeps the divide datapath separate from the top FSM.

Test Plan:
- MUL 7 x -3 (XLEN=32) -> result 0xFFFFFFEB. done at T+34; busy high from T+1 through T+33.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD. REM -7 / 2 -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5. DIV 0x80000000 / -1 -> 0x80000000 and REM -> 0. With DIV_EARLY_OUT=1, done arrives at T+2.
- Start DIVU 100/7, assert flush at T+10 -> busy=0 at T+11, no done, result keeps its prior value. A new start at T+11 completes correctly.
- RST asserted mid-MUL at T+5 -> busy=0, result=0, done=0 next cycle. A start held during busy is ignored, and its operands never appear on result.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M/RV64M multiply/divide unit.
// Holds the funct3 encoding, FSM state type and XLEN-independent decode helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_t;

  function automatic logic is_signed_a(input logic [2:0] f);
    return (f == MD_MULH) || (f == MD_MULHSU) ||
           (f == MD_DIV)  || (f == MD_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f);
    return (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
  endfunction

  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Ports: CLK, RST (sync high), load, flush, dividend, divisor -> quotient, remainder, fin.
module muldiv_div_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            fin
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dsr_q;
  logic [CW-1:0]   cnt_q;
  logic            active_q;

  // XLEN+1-bit partial remainder; top bit of diff is the borrow.
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dsr_q};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (flush) begin
      active_q <= 1'b0;
    end else if (load) begin
      rem_q    <= '0;
      quo_q    <= dividend;
      dsr_q    <= divisor;
      cnt_q    <= CW'(XLEN - 1);
      active_q <= 1'b1;
    end else if (active_q) begin
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shifted[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
      if (cnt_q == '0) begin
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // High during the cycle whose edge performs the last step.
  assign fin       = active_q && (cnt_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M execute unit: shift-add multiply, restoring divide.
// Ports: CLK, RST, start, funct3, op_a, op_b, flush -> busy, done, result. Macro: MULDIV_FAST_MUL_EN.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter bit DIV_EARLY_OUT = 1'b1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state_q, state_d;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] a_raw_q;
  logic [2*XLEN-1:0] prod_q;
  logic            neg_q;
  logic            rneg_q;
  logic            dz_q;
  logic            ovf_q;
  logic [CW-1:0]   cnt_q;

  logic            sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            dz, ovf, early, accept;
  logic [2*XLEN-1:0] prod_init;
  muldiv_state_t   mul_entry;

  logic [XLEN-1:0] div_q, div_r;
  logic            div_fin;

  // Operand magnitudes and special-case detection at latch time.
  always_comb begin
    sa     = is_signed_a(funct3) & op_a[XLEN-1];
    sb     = is_signed_b(funct3) & op_b[XLEN-1];
    a_mag  = sa ? -op_a : op_a;
    b_mag  = sb ? -op_b : op_b;
    dz     = (op_b == '0);
    ovf    = is_signed_a(funct3) && is_div(funct3) &&
             (op_a == MIN_NEG) && (op_b == '1);
    early  = DIV_EARLY_OUT && (dz || ovf);
    accept = start && !flush &&
             ((state_q == ST_IDLE) || (state_q == ST_DONE));
  end

`ifdef MULDIV_FAST_MUL_EN
  assign mul_entry = ST_FIX;
  assign prod_init = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
  logic [2*XLEN-1:0] mul_step;
  assign mul_step  = prod_q;
`else
  logic [XLEN-1:0] a_mag_q;
  logic [XLEN:0]   mul_sum;
  logic [2*XLEN-1:0] mul_step;
  assign mul_entry = ST_MUL;
  assign prod_init = {{XLEN{1'b0}}, b_mag};
  // Multiplier sits in the low half and shifts out as the sum shifts in.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} +
               (prod_q[0] ? {1'b0, a_mag_q} : '0);
    mul_step = {mul_sum, prod_q[XLEN-1:1]};
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_mag_q <= '0;
    end else if (accept) begin
      a_mag_q <= a_mag;
    end
  end
`endif

  muldiv_div_core #(.XLEN(XLEN)) u_div (
    .CLK       (CLK),
    .RST       (RST),
    .load      (accept && is_div(funct3) && !early),
    .flush     (flush),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_q),
    .remainder (div_r),
    .fin       (div_fin)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (is_div(funct3)) state_d = early ? ST_FIX : ST_DIV;
          else                state_d = mul_entry;
        end
      end
      ST_MUL:  if (cnt_q == '0) state_d = ST_FIX;
      ST_DIV:  if (div_fin)     state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (flush && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  // Sign fix-up and result selection.
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_val;

  always_comb begin
    prod_s  = neg_q  ? -prod_q : prod_q;
    quo_s   = neg_q  ? -div_q  : div_q;
    rem_s   = rneg_q ? -div_r  : div_r;
    fix_val = '0;
    unique case (1'b1)
      !f3_q[2]: fix_val = (f3_q[1:0] == 2'b00) ?
                          prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
      dz_q:     fix_val = f3_q[1] ? a_raw_q : '1;
      ovf_q:    fix_val = f3_q[1] ? '0 : a_raw_q;
      default:  fix_val = f3_q[1] ? rem_s : quo_s;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      f3_q    <= '0;
      a_raw_q <= '0;
      prod_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        f3_q    <= funct3;
        a_raw_q <= op_a;
        prod_q  <= prod_init;
        neg_q   <= sa ^ sb;
        rneg_q  <= sa;
        dz_q    <= dz;
        ovf_q   <= ovf;
        cnt_q   <= CW'(XLEN - 1);
      end else if (!flush) begin
        if (state_q == ST_MUL) prod_q <= mul_step;
        if (((state_q == ST_MUL) || (state_q == ST_DIV)) &&
            (cnt_q != '0)) begin
          cnt_q <= cnt_q - 1'b1;
        end
        if (state_q == ST_FIX) result <= fix_val;
      end
    end
  end

  assign busy = (state_q == ST_MUL) || (state_q == ST_DIV) ||
                (state_q == ST_FIX);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit at XLEN=32, DIV_EARLY_OUT=1.
// Table-driven op vectors plus hand sequences for flush, reset and held start.
module tb_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  localparam int LI = 34;
`ifdef MULDIV_FAST_MUL_EN
  localparam int LM = 2;
`else
  localparam int LM = 34;
`endif

  muldiv_unit #(.XLEN(32), .DIV_EARLY_OUT(1'b1)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at a negedge after done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res,
                        output int lat, output int gaps, output logic tail);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    @(negedge CLK);
    start = 1'b0;
    lat = 1; gaps = 0;
    while (!done && lat < 200) begin
      if (!busy) gaps++;
      @(negedge CLK);
      lat++;
    end
    res = result;
    @(negedge CLK);
    tail = done | busy;
  endtask

  logic [31:0] res, prev;
  int lat, gaps, k;
  logic tail, seen;

  initial begin
    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LM};
    vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LM};
    vecs[2]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, LM};
    vecs[3]  = '{3'b001, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, LM};
    vecs[4]  = '{3'b001, 32'h40000000, 32'd4,        32'h00000001, LM};
    vecs[5]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LI};
    vecs[6]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LI};
    vecs[7]  = '{3'b101, 32'd100,      32'd7,        32'd14,       LI};
    vecs[8]  = '{3'b111, 32'd100,      32'd7,        32'd2,        LI};
    vecs[9]  = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 2};
    vecs[10] = '{3'b110, 32'd5,        32'd0,        32'd5,        2};
    vecs[11] = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 2};
    vecs[12] = '{3'b111, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 2};
    vecs[13] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
    vecs[14] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2};
    vecs[15] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        LI};
    vecs[16] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        LI};
    vecs[17] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, LI};

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, gaps, tail);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_busy_gaps", i), gaps, 32'd0);
      chk($sformatf("vec%0d_tail", i), {31'b0, tail}, 32'd0);
    end
    prev = vecs[NV-1].exp;

    // Flush at T+10 of a DIVU, then restart at T+11.
    start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
    @(negedge CLK);
    start = 1'b0;
    seen = 1'b0;
    for (int j = 1; j < 10; j++) begin
      if (done) seen = 1'b1;
      @(negedge CLK);
    end
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_done", {31'b0, done | seen}, 32'd0);
    chk("flush_result", result, prev);
    run_op(3'b101, 32'd100, 32'd7, res, lat, gaps, tail);
    chk("after_flush_result", res, 32'd14);
    chk("after_flush_latency", lat, LI);

    // Flush wins over start in IDLE.
    prev = 32'd14;
    start = 1'b1; flush = 1'b1; funct3 = 3'b000;
    op_a = 32'd3; op_b = 32'd5;
    @(negedge CLK);
    start = 1'b0; flush = 1'b0;
    seen = busy;
    repeat (3) begin
      @(negedge CLK);
      if (busy || done) seen = 1'b1;
    end
    chk("flush_start_idle", {31'b0, seen}, 32'd0);
    chk("flush_start_result", result, prev);

    // Reset at T+5 of a MUL.
    start = 1'b1; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd6;
    @(negedge CLK);
    start = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_done", {31'b0, done}, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    chk("rst_mid_no_done", {31'b0, seen}, 32'd0);

    // Start held during busy with other operands must be ignored.
    start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
    @(negedge CLK);
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3;
    k = 1; seen = 1'b0;
    while (!done && k < 200) begin
      if (k == 20) start = 1'b0;
      if (result == 32'd9) seen = 1'b1;
      @(negedge CLK);
      k++;
    end
    start = 1'b0;
    chk("held_start_result", result, 32'd14);
    chk("held_start_latency", k, LI);
    repeat (3) begin
      @(negedge CLK);
      if (busy || result == 32'd9) seen = 1'b1;
    end
    chk("held_start_ignored", {31'b0, seen}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
